mips_multicycle_controller: RTL and testbench



---
 rtl/mips_multicycle_controller.sv | 203 ++++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional build macro MIPS_MC_ILLEGAL_TRAP_EN traps unknown instructions in ILLEGAL.

package mips_pkg;
    localparam int unsigned INSTR_WITDTH   = 32;
    localparam int unsigned ALU_CTRL_WIDTH = 4;
endpackage

module mips_multicycle_controller
    import mips_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INSTR_WITDTH-1:0]   instr,
    input  logic                      zero,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      memwrite,
    output logic                      iord,
    output logic                      irwrite,
    output logic                      regdst,
    output logic                      memtoreg,
    output logic                      regwrite,
    output logic                      alusrca,
    output logic [1:0]                alusrcb,
    output logic [1:0]                pcsrc,
    output logic                      pcen,
    output logic [ALU_CTRL_WIDTH-1:0] alucontrl,
    output logic                      illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(4'b0010);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(4'b0110);

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    localparam state_t UNKNOWN_NEXT = ILLEGAL;
    localparam logic   ILLEGAL_FLAG = 1'b1;
`else
    localparam state_t UNKNOWN_NEXT = FETCH;
    localparam logic   ILLEGAL_FLAG = 1'b0;
`endif

    state_t                    state_q;
    state_t                    state_d;
    logic [5:0]                opcode;
    logic [5:0]                funct;
    logic                      funct_known;
    logic [ALU_CTRL_WIDTH-1:0] funct_alu;
    logic                      unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    // R-type funct to ALU operation; unlisted functs are flagged as unknown
    always_comb begin
        funct_known = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct)
            6'b000000: funct_alu = ALU_CTRL_WIDTH'(4'b1000);
            6'b000010: funct_alu = ALU_CTRL_WIDTH'(4'b1001);
            6'b000011: funct_alu = ALU_CTRL_WIDTH'(4'b1010);
            6'b000100: funct_alu = ALU_CTRL_WIDTH'(4'b1011);
            6'b000110: funct_alu = ALU_CTRL_WIDTH'(4'b1100);
            6'b000111: funct_alu = ALU_CTRL_WIDTH'(4'b1101);
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_CTRL_WIDTH'(4'b0000);
            6'b100101: funct_alu = ALU_CTRL_WIDTH'(4'b0001);
            6'b100110: funct_alu = ALU_CTRL_WIDTH'(4'b0011);
            6'b100111: funct_alu = ALU_CTRL_WIDTH'(4'b0100);
            6'b101010: funct_alu = ALU_CTRL_WIDTH'(4'b0111);
            default:   funct_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; memory states hold until mem_ready
    always_comb begin
        state_d   = FETCH;
        mem_req   = 1'b0;
        memwrite  = 1'b0;
        iord      = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        pcen      = 1'b0;
        alucontrl = ALU_ADD;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_known ? EXECUTE : UNKNOWN_NEXT;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = UNKNOWN_NEXT;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alusrca   = 1'b1;
                alucontrl = funct_alu;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca   = 1'b1;
                alucontrl = ALU_SUB;
                pcsrc     = 2'b01;
                pcen      = zero;
                state_d   = FETCH;
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = FETCH;
            end
            ILLEGAL: begin
                illegal = ILLEGAL_FLAG;
                state_d = ILLEGAL;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized bench for mips_multicycle_controller against a per-instruction phase-list model.
module tb_mips_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0]  alusrcb, pcsrc;
    logic [3:0]  alucontrl;

    mips_multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrl(alucontrl), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] dut_vec;
    assign dut_vec = {mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                      alusrcb, pcsrc, pcen, alucontrl, illegal};

    localparam logic [17:0] FETCH_IDLE = 18'h20104;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
                      P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_ILLEGAL} phase_t;

    int vectors = 0;
    int miscompares = 0;
    phase_t seq[$];

    logic [5:0] legal_funct [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                     6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'h00: return 4'b1000;  6'h02: return 4'b1001;  6'h03: return 4'b1010;
            6'h04: return 4'b1011;  6'h06: return 4'b1100;  6'h07: return 4'b1101;
            6'h20: return 4'b0010;  6'h22: return 4'b0110;  6'h24: return 4'b0000;
            6'h25: return 4'b0001;  6'h26: return 4'b0011;  6'h27: return 4'b0100;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        foreach (legal_funct[i]) if (legal_funct[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Expected output word for one cycle of a phase
    function automatic logic [17:0] expect_vec(input phase_t p, input logic [31:0] ins,
                                               input logic z, input logic rdy);
        logic mreq, mw, io, irw, rdst, m2r, rw, asa, pce, ill;
        logic [1:0] asb, pcs;
        logic [3:0] alu;
        {mreq, mw, io, irw, rdst, m2r, rw, asa, pce, ill} = '0;
        asb = 2'b00;
        pcs = 2'b00;
        alu = 4'b0010;
        case (p)
            P_FETCH:   begin mreq = 1; asb = 2'b01; irw = rdy; pce = rdy; end
            P_DECODE:  asb = 2'b11;
            P_MEMADR:  begin asa = 1; asb = 2'b10; end
            P_MEMRD:   begin mreq = 1; io = 1; end
            P_MEMWB:   begin rw = 1; m2r = 1; end
            P_MEMWR:   begin mreq = 1; mw = 1; io = 1; end
            P_EXEC:    begin asa = 1; alu = alu_of(ins[5:0]); end
            P_ALUWB:   begin rw = 1; rdst = 1; end
            P_BRANCH:  begin asa = 1; alu = 4'b0110; pcs = 2'b01; pce = z; end
            P_ADDIEX:  begin asa = 1; asb = 2'b10; end
            P_ADDIWB:  rw = 1;
            P_JUMP:    begin pcs = 2'b10; pce = 1; end
            default:   ill = 1;
        endcase
        return {mreq, mw, io, irw, rdst, m2r, rw, asa, asb, pcs, pce, alu, ill};
    endfunction

    task automatic build_seq(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        seq = '{P_FETCH, P_DECODE};
        if (!op_ok(op) || (op == 6'b000000 && !funct_ok(ins[5:0]))) begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            repeat (10) seq.push_back(P_ILLEGAL);
`endif
        end else begin
            case (op)
                6'b100011: seq = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB};
                6'b101011: seq = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWR};
                6'b000000: seq = '{P_FETCH, P_DECODE, P_EXEC, P_ALUWB};
                6'b000100: seq = '{P_FETCH, P_DECODE, P_BRANCH};
                6'b001000: seq = '{P_FETCH, P_DECODE, P_ADDIEX, P_ADDIWB};
                default:   seq = '{P_FETCH, P_DECODE, P_JUMP};
            endcase
        end
    endtask

    task automatic check(input string name, input logic [17:0] exp);
        vectors++;
        if (dut_vec !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, dut_vec, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        instr = $urandom;
        #1 check("reset_fetch", FETCH_IDLE);
        @(negedge clk);
        #1 check("reset_hold", expect_vec(P_FETCH, instr, zero, 1'b0));
        rst_n = 1'b1;
    endtask

    // waits_req<0: random ready delays; zero_force<0: random zero; pin_idx: literal check phase
    task automatic run_instr(input logic [31:0] ins, input int waits_req, input int zero_force,
                             input int pin_idx, input logic [17:0] pin_vec, input int rst_at);
        build_seq(ins);
        for (int i = 0; i < seq.size(); i++) begin
            phase_t p;
            bit     mem;
            int     waits;
            p = seq[i];
            mem = (p == P_FETCH || p == P_MEMRD || p == P_MEMWR);
            waits = !mem ? 0 : (waits_req < 0 ? int'($urandom_range(0, 3)) : waits_req);
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                instr = (p == P_FETCH) ? 32'($urandom) : ins;
                zero = (zero_force < 0) ? 1'($urandom) : 1'(zero_force);
                mem_ready = mem ? (w == waits) : 1'($urandom);
                #1 check(p.name(), expect_vec(p, instr, zero, mem_ready));
                if (i == pin_idx && w == 0) check("pinned", pin_vec);
                if (i == rst_at) begin
                    #2 rst_n = 1'b0;
                    mem_ready = 1'b0;
                    #1 check("async_reset", FETCH_IDLE);
                    @(negedge clk);
                    #1 check("reset_hold", expect_vec(P_FETCH, instr, zero, 1'b0));
                    rst_n = 1'b1;
                    return;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  op;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 8);
        case (k)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2, 3: begin op = 6'b000000; r[5:0] = legal_funct[$urandom_range(0, 12)]; end
            4: op = 6'b000100;
            5: op = 6'b001000;
            6: op = 6'b000010;
            7: begin op = 6'b000000; while (funct_ok(r[5:0])) r[5:0] = 6'($urandom); end
            default: begin op = 6'($urandom); while (op_ok(op)) op = 6'($urandom); end
        endcase
        r[31:26] = op;
        return r;
    endfunction

    initial begin
        logic [31:0] ins;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        instr = 32'h0;
        zero = 1'b0;
        #1 check("reset_lit", FETCH_IDLE);
        @(negedge clk);
        #1 check("reset_model", expect_vec(P_FETCH, instr, zero, 1'b0));
        rst_n = 1'b1;

        run_instr(32'h8C0A0004, 0, -1, 4, 18'h01804, -1);               // LW, MEMWB pinned
        run_instr(32'hAC0A0008, 3, -1, 3, 18'h38004, -1);               // SW with 3 waits
        run_instr(32'h012A4007, 0, -1, 2, 18'h0041A, -1);               // SRAV
        run_instr(32'h012A402A, 0, -1, 2, 18'h0040E, -1);               // SLT
        run_instr(32'h112A0004, 0, 1, 2, 18'h0046C, -1);                // BEQ taken
        run_instr(32'h112A0004, 0, 0, 2, 18'h0044C, -1);                // BEQ not taken
        run_instr(32'h08000010, 0, -1, 2, 18'h000A4, -1);               // J
        run_instr(32'hFC000000, 0, -1, 1, 18'h00304, -1);               // opcode 111111
        apply_reset();
        run_instr(32'h8C0A0004, 1, -1, -1, 18'h0, 3);                   // reset in MEMRD
        run_instr(32'h8C0B0010, 0, -1, -1, 18'h0, -1);

        for (int n = 0; n < 200; n++) begin
            ins = rand_instr();
            run_instr(ins, -1, -1, -1, 18'h0, ($urandom_range(0, 19) == 0) ? 2 : -1);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            if (seq[seq.size()-1] == P_ILLEGAL) apply_reset();
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
